// File: rtl/mem_pipe_pkg.sv
// rtl/mem_pipe_pkg.sv - shared types, limits and byte-lane merge helper for mem_pipe_ctrl
package mem_pipe_pkg;

    localparam int MAX_RD_LATENCY = 4;
    localparam int MAX_DATA_WIDTH = 64;
    localparam int MAX_BE_WIDTH   = MAX_DATA_WIDTH / 8;

    // Response payload; narrower data widths are zero-extended into rdata.
    typedef struct packed {
        logic                      err;
        logic [MAX_DATA_WIDTH-1:0] rdata;
    } mem_rsp_t;

    // Replace byte lane i of old_word with the same lane of new_word where be[i] is set.
    function automatic logic [MAX_DATA_WIDTH-1:0] be_merge(
        input logic [MAX_DATA_WIDTH-1:0] old_word,
        input logic [MAX_DATA_WIDTH-1:0] new_word,
        input logic [MAX_BE_WIDTH-1:0]   be
    );
        logic [MAX_DATA_WIDTH-1:0] merged;
        merged = old_word;
        for (int i = 0; i < MAX_BE_WIDTH; i++) begin
            if (be[i]) begin
                merged[i*8 +: 8] = new_word[i*8 +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/mem_rsp_fifo.sv
// rtl/mem_rsp_fifo.sv - response buffer FIFO with arbitrary (non-power-of-two) depth
module mem_rsp_fifo #(
    parameter  int DEPTH = 2,
    parameter  int WIDTH = 8,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [CNT_W-1:0] count
);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] slot_q [DEPTH];

    // Pointers wrap at DEPTH-1 explicitly because DEPTH need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Next-state for pointers and occupancy; the caller never pushes when full or pops when empty.
    always_comb begin
        wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers; reset empties the buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage needs no reset: an empty buffer never exposes it.
    always_ff @(posedge clk) begin
        if (push) begin
            slot_q[wr_ptr_q] <= push_data;
        end
    end

    assign head_data = (count_q != '0) ? slot_q[rd_ptr_q] : '0;
    assign count     = count_q;

endmodule

// File: rtl/mem_pipe_ctrl.sv
// rtl/mem_pipe_ctrl.sv - single-port memory with valid/ready requests, byte enables and pipelined in-order responses
module mem_pipe_ctrl
    import mem_pipe_pkg::*;
#(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 2 ** ADDR_WIDTH,
    parameter int RD_LATENCY = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    input  logic [DATA_WIDTH/8-1:0] req_be,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_err
);

    localparam int RSP_DEPTH = RD_LATENCY + 1;
    localparam int CNT_W     = $clog2(RSP_DEPTH + 1);
    localparam int MEM_AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    if ((DATA_WIDTH % 8) != 0 || DATA_WIDTH > MAX_DATA_WIDTH) begin : g_bad_data_width
        $error("mem_pipe_ctrl: DATA_WIDTH must be a multiple of 8 and at most %0d", MAX_DATA_WIDTH);
    end
    if (RD_LATENCY < 1 || RD_LATENCY > MAX_RD_LATENCY) begin : g_bad_rd_latency
        $error("mem_pipe_ctrl: RD_LATENCY must lie in 1..%0d", MAX_RD_LATENCY);
    end
    if (DEPTH < 1 || DEPTH > (1 << ADDR_WIDTH)) begin : g_bad_depth
        $error("mem_pipe_ctrl: DEPTH must lie in 1..2**ADDR_WIDTH");
    end

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic                  accept;
    logic                  pop;
    logic                  in_range;
    logic [MEM_AW-1:0]     mem_idx;
    logic [DATA_WIDTH-1:0] rd_word;
    mem_rsp_t              new_rsp;
    logic [CNT_W-1:0]      outstanding_q, outstanding_d;
    logic                  fifo_push;
    mem_rsp_t              fifo_push_data;
    mem_rsp_t              fifo_head;
    logic [CNT_W-1:0]      fifo_count;
    logic                  unused_rsp_hi;

    // Request decode: range check, array read and the response this request will produce.
    always_comb begin
        in_range      = {1'b0, req_addr} < (ADDR_WIDTH + 1)'(DEPTH);
        mem_idx       = MEM_AW'(req_addr);
        rd_word       = mem[mem_idx];
        accept        = req_valid && req_ready;
        new_rsp.err   = !in_range;
        new_rsp.rdata = (in_range && !req_write) ? MAX_DATA_WIDTH'(rd_word) : '0;
    end

    // Byte-lane write on the accept edge; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (accept && req_write && in_range) begin
            mem[mem_idx] <= DATA_WIDTH'(be_merge(MAX_DATA_WIDTH'(rd_word),
                                                 MAX_DATA_WIDTH'(req_wdata),
                                                 MAX_BE_WIDTH'(req_be)));
        end
    end

    // RD_LATENCY-1 register stages between the array read and the response buffer.
    if (RD_LATENCY == 1) begin : g_no_pipe
        assign fifo_push      = accept;
        assign fifo_push_data = new_rsp;
    end else begin : g_pipe
        localparam int NSTG = RD_LATENCY - 1;
        logic [NSTG-1:0] vld_q, vld_d;
        mem_rsp_t        rsp_q [NSTG];
        mem_rsp_t        rsp_d [NSTG];

        // Stages always advance: the outstanding limit guarantees buffer room on arrival.
        always_comb begin
            vld_d    = vld_q;
            rsp_d    = rsp_q;
            vld_d[0] = accept;
            rsp_d[0] = new_rsp;
            for (int i = 1; i < NSTG; i++) begin
                vld_d[i] = vld_q[i-1];
                rsp_d[i] = rsp_q[i-1];
            end
        end

        // Stage registers; reset drops anything in flight.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_q <= '0;
                for (int i = 0; i < NSTG; i++) begin
                    rsp_q[i] <= '0;
                end
            end else begin
                vld_q <= vld_d;
                rsp_q <= rsp_d;
            end
        end

        assign fifo_push      = vld_q[NSTG-1];
        assign fifo_push_data = rsp_q[NSTG-1];
    end

    // Outstanding = accepted but not yet popped; a simultaneous accept and pop cancel.
    always_comb begin
        outstanding_d = outstanding_q;
        if (accept && !pop) begin
            outstanding_d = outstanding_q + 1'b1;
        end else if (pop && !accept) begin
            outstanding_d = outstanding_q - 1'b1;
        end
    end

    // Outstanding counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outstanding_q <= '0;
        end else begin
            outstanding_q <= outstanding_d;
        end
    end

    mem_rsp_fifo #(
        .DEPTH (RSP_DEPTH),
        .WIDTH ($bits(mem_rsp_t))
    ) u_rsp_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifo_push),
        .push_data (fifo_push_data),
        .pop       (pop),
        .head_data (fifo_head),
        .count     (fifo_count)
    );

    assign req_ready     = rst_n && (outstanding_q < CNT_W'(RSP_DEPTH));
    assign rsp_valid     = (fifo_count != '0);
    assign pop           = rsp_valid && rsp_ready;
    assign rsp_err       = fifo_head.err;
    assign rsp_rdata     = DATA_WIDTH'(fifo_head.rdata);
    assign unused_rsp_hi = ^fifo_head.rdata;

endmodule

// File: tb/tb_mem_pipe_ctrl.sv
// tb/tb_mem_pipe_ctrl.sv - directed self-checking bench for mem_pipe_ctrl
module tb_mem_pipe_ctrl;

    logic clk;
    logic rst_n;

    // a: defaults (8-bit, 32 words, latency 1)
    logic       a_req_valid, a_req_ready, a_req_write, a_rsp_valid, a_rsp_ready, a_rsp_err;
    logic [4:0] a_req_addr;
    logic [7:0] a_req_wdata, a_rsp_rdata;
    logic [0:0] a_req_be;

    // b: 32-bit data, 20 words, latency 3
    logic        b_req_valid, b_req_ready, b_req_write, b_rsp_valid, b_rsp_ready, b_rsp_err;
    logic [4:0]  b_req_addr;
    logic [31:0] b_req_wdata, b_rsp_rdata;
    logic [3:0]  b_req_be;

    // c: 8-bit data, 32 words, latency 2
    logic       c_req_valid, c_req_ready, c_req_write, c_rsp_valid, c_rsp_ready, c_rsp_err;
    logic [4:0] c_req_addr;
    logic [7:0] c_req_wdata, c_rsp_rdata;
    logic [0:0] c_req_be;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_acc;
    logic exp_rdy;

    mem_pipe_ctrl u_a (
        .clk(clk), .rst_n(rst_n),
        .req_valid(a_req_valid), .req_ready(a_req_ready), .req_write(a_req_write),
        .req_addr(a_req_addr), .req_wdata(a_req_wdata), .req_be(a_req_be),
        .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready), .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err)
    );

    mem_pipe_ctrl #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .DEPTH(20), .RD_LATENCY(3)) u_b (
        .clk(clk), .rst_n(rst_n),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(b_req_write),
        .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_be(b_req_be),
        .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err)
    );

    mem_pipe_ctrl #(.RD_LATENCY(2)) u_c (
        .clk(clk), .rst_n(rst_n),
        .req_valid(c_req_valid), .req_ready(c_req_ready), .req_write(c_req_write),
        .req_addr(c_req_addr), .req_wdata(c_req_wdata), .req_be(c_req_be),
        .rsp_valid(c_rsp_valid), .rsp_ready(c_rsp_ready), .rsp_rdata(c_rsp_rdata), .rsp_err(c_rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        a_req_valid = 0; a_req_write = 0; a_req_addr = '0; a_req_wdata = '0; a_req_be = '0; a_rsp_ready = 1;
        b_req_valid = 0; b_req_write = 0; b_req_addr = '0; b_req_wdata = '0; b_req_be = '0; b_rsp_ready = 1;
        c_req_valid = 0; c_req_write = 0; c_req_addr = '0; c_req_wdata = '0; c_req_be = '0; c_rsp_ready = 1;
        #2;
        chk("rst_a_req_ready", 64'(a_req_ready), 64'h0);
        chk("rst_a_rsp_valid", 64'(a_rsp_valid), 64'h0);
        chk("rst_a_rsp_rdata", 64'(a_rsp_rdata), 64'h0);
        chk("rst_a_rsp_err",   64'(a_rsp_err),   64'h0);
        chk("rst_b_req_ready", 64'(b_req_ready), 64'h0);
        chk("rst_b_rsp_valid", 64'(b_rsp_valid), 64'h0);
        chk("rst_c_req_ready", 64'(c_req_ready), 64'h0);
        tick();
        tick();
        #2 rst_n = 1'b1;
        #1;
        chk("rel_a_req_ready", 64'(a_req_ready), 64'h1);
        chk("rel_b_req_ready", 64'(b_req_ready), 64'h1);
        chk("rel_c_req_ready", 64'(c_req_ready), 64'h1);
        tick();

        // a: write 0xA5 to addr 3, then read it back one cycle later
        a_req_valid = 1; a_req_write = 1; a_req_addr = 5'd3; a_req_wdata = 8'hA5; a_req_be = 1'b1;
        chk("a_idle_rsp_valid", 64'(a_rsp_valid), 64'h0);
        tick();
        a_req_write = 0;
        chk("a_ack_valid", 64'(a_rsp_valid), 64'h1);
        chk("a_ack_rdata", 64'(a_rsp_rdata), 64'h0);
        chk("a_ack_err",   64'(a_rsp_err),   64'h0);
        tick();
        a_req_valid = 0;
        chk("a_rd_valid", 64'(a_rsp_valid), 64'h1);
        chk("a_rd_rdata", 64'(a_rsp_rdata), 64'hA5);
        chk("a_rd_err",   64'(a_rsp_err),   64'h0);
        tick();
        chk("a_drained_valid", 64'(a_rsp_valid), 64'h0);
        // a: write with no byte enables must leave the word alone
        a_req_valid = 1; a_req_write = 1; a_req_wdata = 8'hFF; a_req_be = 1'b0;
        tick();
        a_req_write = 0;
        chk("a_be0_ack_valid", 64'(a_rsp_valid), 64'h1);
        tick();
        a_req_valid = 0;
        chk("a_be0_rdata", 64'(a_rsp_rdata), 64'hA5);
        tick();

        // b: fill all 20 words
        for (int i = 0; i < 20; i++) begin
            b_req_valid = 1; b_req_write = 1; b_req_addr = 5'(i);
            b_req_wdata = 32'hC0DE0000 | 32'(i); b_req_be = 4'hF;
            tick();
        end
        b_req_valid = 0;
        repeat (4) tick();

        // b: full write, partial write, read of addr 7
        b_req_valid = 1; b_req_write = 1; b_req_addr = 5'd7; b_req_wdata = 32'h11223344; b_req_be = 4'hF;
        tick();
        b_req_wdata = 32'hFFFFFFFF; b_req_be = 4'b0101;
        tick();
        chk("b_no_early_rsp", 64'(b_rsp_valid), 64'h0);
        b_req_write = 0;
        tick();
        b_req_valid = 0;
        chk("b_wr1_ack_valid", 64'(b_rsp_valid), 64'h1);
        tick();
        chk("b_wr2_ack_valid", 64'(b_rsp_valid), 64'h1);
        chk("b_wr2_ack_rdata", 64'(b_rsp_rdata), 64'h0);
        tick();
        chk("b_merge_valid", 64'(b_rsp_valid), 64'h1);
        chk("b_merge_rdata", 64'(b_rsp_rdata), 64'h11FF33FF);
        chk("b_merge_err",   64'(b_rsp_err),   64'h0);
        tick();
        chk("b_merge_single", 64'(b_rsp_valid), 64'h0);

        // b: out-of-range read and write
        b_req_valid = 1; b_req_write = 0; b_req_addr = 5'd25;
        tick();
        b_req_write = 1; b_req_addr = 5'd31; b_req_wdata = 32'hFFFFFFFF; b_req_be = 4'hF;
        tick();
        b_req_valid = 0;
        tick();
        chk("b_err_rd_valid", 64'(b_rsp_valid), 64'h1);
        chk("b_err_rd_err",   64'(b_rsp_err),   64'h1);
        chk("b_err_rd_rdata", 64'(b_rsp_rdata), 64'h0);
        tick();
        chk("b_err_wr_valid", 64'(b_rsp_valid), 64'h1);
        chk("b_err_wr_err",   64'(b_rsp_err),   64'h1);
        chk("b_err_wr_rdata", 64'(b_rsp_rdata), 64'h0);
        tick();

        // b: streaming sweep of 0..19, responses three cycles behind requests
        for (int c = 0; c < 22; c++) begin
            if (c < 20) begin
                b_req_valid = 1; b_req_write = 0; b_req_addr = 5'(c);
            end else begin
                b_req_valid = 0;
            end
            tick();
            if (c >= 2) begin
                chk("b_sweep_valid", 64'(b_rsp_valid), 64'h1);
                chk("b_sweep_err",   64'(b_rsp_err),   64'h0);
                chk("b_sweep_rdata", 64'(b_rsp_rdata),
                    (c - 2 == 7) ? 64'h11FF33FF : 64'(32'hC0DE0000 | 32'(c - 2)));
            end
        end

        // c: fill words 0..15 with 0x40+i
        for (int i = 0; i < 16; i++) begin
            c_req_valid = 1; c_req_write = 1; c_req_addr = 5'(i); c_req_wdata = 8'(8'h40 + i); c_req_be = 1'b1;
            tick();
        end
        c_req_valid = 0;
        repeat (3) tick();

        // c: backpressure, exactly three accepts then req_ready drops
        c_rsp_ready = 0; c_req_valid = 1; c_req_write = 0; c_req_addr = 5'd0; n_acc = 0;
        for (int c = 0; c < 6; c++) begin
            exp_rdy = (n_acc < 3);
            chk("c_bp_req_ready", 64'(c_req_ready), 64'(exp_rdy));
            tick();
            if (exp_rdy) n_acc++;
            c_req_addr = 5'(n_acc);
            if (c >= 1) begin
                chk("c_bp_head_valid", 64'(c_rsp_valid), 64'h1);
                chk("c_bp_head_rdata", 64'(c_rsp_rdata), 64'h40);
            end
        end

        // c: release the consumer; in-order responses then one per cycle
        c_rsp_ready = 1;
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("c_stream_valid",     64'(c_rsp_valid), 64'h1);
            chk("c_stream_rdata",     64'(c_rsp_rdata), 64'(8'h41 + k));
            chk("c_stream_req_ready", 64'(c_req_ready), 64'h1);
            c_req_addr = 5'(3 + k);
        end
        c_req_valid = 0;
        repeat (4) tick();

        // c: 16 back-to-back reads, then reset with traffic still in flight
        for (int c = 0; c < 17; c++) begin
            c_req_valid = 1; c_req_write = 0; c_req_addr = 5'(c % 16);
            tick();
            if (c >= 1) begin
                chk("c_b2b_valid", 64'(c_rsp_valid), 64'h1);
                chk("c_b2b_rdata", 64'(c_rsp_rdata), 64'(8'h40 + (c - 1)));
            end
        end
        #3 rst_n = 1'b0;
        #1;
        chk("c_midrst_rsp_valid", 64'(c_rsp_valid), 64'h0);
        chk("c_midrst_req_ready", 64'(c_req_ready), 64'h0);
        chk("c_midrst_rsp_rdata", 64'(c_rsp_rdata), 64'h0);
        c_req_valid = 0;
        tick();
        #2 rst_n = 1'b1;
        #1;
        chk("c_post_rst_ready", 64'(c_req_ready), 64'h1);
        chk("c_post_rst_valid", 64'(c_rsp_valid), 64'h0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("c_no_stale_valid", 64'(c_rsp_valid), 64'h0);
        end

        // memory contents survive reset
        c_req_valid = 1; c_req_write = 0; c_req_addr = 5'd5;
        a_req_valid = 1; a_req_write = 0; a_req_addr = 5'd3;
        tick();
        c_req_valid = 0; a_req_valid = 0;
        chk("a_keep_valid", 64'(a_rsp_valid), 64'h1);
        chk("a_keep_rdata", 64'(a_rsp_rdata), 64'hA5);
        chk("c_keep_not_yet", 64'(c_rsp_valid), 64'h0);
        tick();
        chk("c_keep_valid", 64'(c_rsp_valid), 64'h1);
        chk("c_keep_rdata", 64'(c_rsp_rdata), 64'h45);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_pipe_ctrl.md
# mem_pipe_ctrl

Parametrised single-port synchronous memory with a valid/ready request port, byte-enable writes, configurable read latency and a backpressurable response port. It replaces the fixed 5-bit/8-bit read/write memory used by the lab benches, and adds the pieces that memory lacks: flow control, pipelined reads, per-byte writes and out-of-range detection. Every accepted request produces exactly one in-order response, so benches can scoreboard strictly by order.

## Interface
- ADDR_WIDTH, 5, request address width
- DATA_WIDTH, 8, data width; must be a multiple of 8
- DEPTH, 2**ADDR_WIDTH, number of words; 1 ≤ DEPTH ≤ 2**ADDR_WIDTH
- RD_LATENCY, 1, request-to-response latency in cycles; legal range 1..4
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  request can be accepted
- req_write  in  1  1 = write, 0 = read
- req_addr  in  ADDR_WIDTH  word address
- req_wdata  in  DATA_WIDTH  write data
- req_be  in  DATA_WIDTH/8  byte enables; writes only
- rsp_valid  out  1  response at buffer head
- rsp_ready  in  1  consumer accepts response
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and errors
- rsp_err  out  1  request address ≥ DEPTH

## Operation
- Accept on a rising edge when req_valid && req_ready. Pop on a rising edge when rsp_valid && rsp_ready.
- Legal write (addr < DEPTH): on the accept edge, byte lane i of mem[addr] is updated only where req_be[i] = 1. The response is an ack with rdata = 0 and err = 0.
- Legal read: mem[addr] is read on the accept edge. Response carries that data with err = 0.
- Illegal address (addr ≥ DEPTH): the array is neither read nor written. Response has err = 1 and rdata = 0.
- Write with req_be = 0: no array change; an ack is still returned.
- Ordering:
  - Responses return strictly in acceptance order.
  - A read accepted the cycle after a write to the same address returns the written data.
- Flow control:
  - Response buffer depth is RSP_DEPTH = RD_LATENCY + 1.
  - Counter `outstanding` counts requests that are accepted but not yet popped.
  - req_ready = (outstanding < RSP_DEPTH).
  - On an edge with both accept and pop, the counter is unchanged.
  - The counter never exceeds RSP_DEPTH. The buffer can therefore never overflow, and no response is ever dropped.
- A response pipeline of RD_LATENCY−1 register stages carries {valid, err, rdata} into the buffer.
- Memory contents are not cleared by reset.

## Timing
- Let the accept cycle be cycle 0. With an empty buffer, rsp_valid is high in cycle RD_LATENCY.
- Back-to-back throughput: one request per cycle, indefinitely, while rsp_ready is held high.
- If rsp_ready stays low, req_ready falls after RSP_DEPTH accepts. It rises in the cycle after the first pop.
- rsp_valid, rsp_rdata and rsp_err come from the buffer head. They stay stable while rsp_valid && !rsp_ready.
- Reset values, applied asynchronously:
  - req_ready = 0 while rst_n is low, then 1 in the first cycle after release.
  - rsp_valid = 0, rsp_rdata = 0, rsp_err = 0.
  - outstanding = 0; all pipeline and buffer state is empty.
- Reset mid-operation: all in-flight and buffered responses are discarded without being emitted. Writes already accepted remain in memory.
- Counter and buffer pointers are sized to hold 0..RSP_DEPTH. Pointers wrap modulo RSP_DEPTH, which is not necessarily a power of two.

## Structure
- Package `mem_pipe_pkg`:
  - `mem_rsp_t` struct {err, rdata}, parametrised through a DATA_WIDTH localparam or type parameter.
  - `MAX_RD_LATENCY = 4`.
  - Function `be_merge(old, new, be)` for the byte-lane write.
- Sub-module `mem_rsp_fifo`:
  - Parametrised depth and width; push/pop with a count output.
  - Non-power-of-two wrap.
  - Instantiated once for the response buffer.
- Elaboration-time assertions: DATA_WIDTH % 8 == 0, 1 ≤ RD_LATENCY ≤ 4, DEPTH ≤ 2**ADDR_WIDTH.

## Test plan
- Defaults, rsp_ready = 1:
  - Write 0xA5 to addr 3 with be = 1, then read addr 3. Expect responses: ack (rdata = 0, err = 0), then rdata = 0xA5.
  - The read response is high exactly 1 cycle after its accept.
- DATA_WIDTH = 32, RD_LATENCY = 3:
  - Write 0x11223344 to addr 7 with be = 4'b1111, then 0xFFFFFFFF with be = 4'b0101, then read addr 7.
  - Expect rdata = 0x11FF33FF, rsp_valid 3 cycles after the read's accept.
- DEPTH = 20, ADDR_WIDTH = 5: read addr 25 and write addr 31 → both responses have err = 1, rdata = 0. Memory is unchanged, checked by a sweep read of 0..19.
- RD_LATENCY = 2, rsp_ready = 0, req_valid held high:
  - Exactly 3 accepts occur, then req_ready = 0.
  - Raise rsp_ready → responses emerge in order, and streaming continues at one response per cycle.
- 16 back-to-back reads, then rst_n pulsed low mid-stream:
  - rsp_valid = 0 and req_ready = 0 immediately.
  - After release, no stale responses appear and req_ready = 1.
  - Earlier written data is still readable.
